// File: rtl/game_seq.sv
// game_seq: top-level game controller for space_invaders.
// Sequences the per-frame player/bullet/alien updates through a req/done
// handshake, owns the lives and score registers, and runs the game FSM.
module game_seq #(
  parameter int unsigned LIVES_INIT        = 3,
  parameter int unsigned SCORE_MAX         = 9,
  parameter int unsigned ALIEN_STEP_FRAMES = 30,
  parameter int unsigned HIT_PAUSE_FRAMES  = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       btn_shoot_p,
  input  logic       btn_rst_p,
  output logic [2:0] upd_req,
  input  logic [2:0] upd_done,
  output logic       alien_step,
  input  logic       alien_killed,
  input  logic       player_hit,
  input  logic       aliens_cleared,
  input  logic       aliens_landed,
  output logic       level_rst,
  output logic [3:0] lives,
  output logic [3:0] score,
  output logic       play_en,
  output logic       game_over,
  output logic       overrun
);

  localparam int unsigned SW = $clog2(ALIEN_STEP_FRAMES + 1);
  localparam int unsigned PW = $clog2(HIT_PAUSE_FRAMES + 1);
  localparam logic [3:0] LIVES_LOAD = 4'(LIVES_INIT);
  localparam logic [3:0] SCORE_SAT  = 4'(SCORE_MAX);
  localparam logic [SW-1:0] STEP_LAST  = SW'(ALIEN_STEP_FRAMES - 1);
  localparam logic [PW-1:0] PAUSE_LAST = PW'(HIT_PAUSE_FRAMES - 1);

  typedef enum logic [3:0] {
    IDLE,
    PLAY_WAIT,
    UPD_PLAYER,
    UPD_BULLET,
    UPD_ALIEN,
    CHECK,
    HIT_PAUSE,
    WIN,
    OVER
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [SW-1:0] step_cnt;
  logic [PW-1:0] pause_cnt;
  logic          hit_latch;
  logic          hit_now;
  logic          in_seq;

  // A hit arriving in the CHECK cycle itself is folded into that decision
  // rather than carried into the next frame.
  assign hit_now = hit_latch | player_hit;
  assign in_seq  = (state == UPD_PLAYER) || (state == UPD_BULLET) ||
                   (state == UPD_ALIEN)  || (state == CHECK);

  // Next-state decision; registered outputs are derived from it below.
  always_comb begin
    state_nxt = state;
    if (btn_rst_p) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, OVER: if (btn_shoot_p) state_nxt = PLAY_WAIT;
        PLAY_WAIT:  if (frame_tick)  state_nxt = UPD_PLAYER;
        UPD_PLAYER: if (upd_done[0]) state_nxt = UPD_BULLET;
        UPD_BULLET: if (upd_done[1]) state_nxt = UPD_ALIEN;
        UPD_ALIEN:  if (upd_done[2]) state_nxt = CHECK;
        CHECK: begin
          if (aliens_landed)       state_nxt = OVER;
          else if (hit_now)        state_nxt = (lives <= 4'd1) ? OVER : HIT_PAUSE;
          else if (aliens_cleared) state_nxt = WIN;
          else                     state_nxt = PLAY_WAIT;
        end
        HIT_PAUSE: if (frame_tick && pause_cnt == PAUSE_LAST) state_nxt = PLAY_WAIT;
        WIN:       if (btn_shoot_p) state_nxt = PLAY_WAIT;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  // State, counters, lives/score and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      upd_req    <= '0;
      alien_step <= 1'b0;
      level_rst  <= 1'b0;
      lives      <= LIVES_LOAD;
      score      <= '0;
      step_cnt   <= '0;
      pause_cnt  <= '0;
      hit_latch  <= 1'b0;
      overrun    <= 1'b0;
      play_en    <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      state     <= state_nxt;
      upd_req   <= {state_nxt == UPD_ALIEN, state_nxt == UPD_BULLET,
                    state_nxt == UPD_PLAYER};
      play_en   <= (state_nxt == PLAY_WAIT) || (state_nxt == UPD_PLAYER) ||
                   (state_nxt == UPD_BULLET) || (state_nxt == UPD_ALIEN) ||
                   (state_nxt == CHECK);
      game_over <= (state_nxt == OVER);
      level_rst <= 1'b0;

      if (btn_rst_p) begin
        lives      <= LIVES_LOAD;
        score      <= '0;
        step_cnt   <= '0;
        pause_cnt  <= '0;
        hit_latch  <= 1'b0;
        overrun    <= 1'b0;
        alien_step <= 1'b0;
      end else begin
        if (play_en && alien_killed && score < SCORE_SAT)
          score <= score + 4'd1;

        if (state == CHECK)
          hit_latch <= 1'b0;
        else if (play_en && player_hit)
          hit_latch <= 1'b1;

        if (frame_tick && in_seq)
          overrun <= 1'b1;

        // Step decision is taken once on entry and held for the whole visit.
        if (state_nxt == UPD_ALIEN && state != UPD_ALIEN) begin
          if (step_cnt == STEP_LAST) begin
            step_cnt   <= '0;
            alien_step <= 1'b1;
          end else begin
            step_cnt   <= step_cnt + 1'b1;
            alien_step <= 1'b0;
          end
        end else if (state_nxt != UPD_ALIEN) begin
          alien_step <= 1'b0;
        end

        case (state)
          IDLE, OVER: begin
            if (btn_shoot_p) begin
              level_rst <= 1'b1;
              lives     <= LIVES_LOAD;
              score     <= '0;
              step_cnt  <= '0;
              hit_latch <= 1'b0;
            end
          end
          CHECK: begin
            if (aliens_landed) begin
              lives <= '0;
            end else if (hit_now) begin
              if (lives != 4'd0) lives <= lives - 4'd1;
              pause_cnt <= '0;
            end
          end
          HIT_PAUSE: begin
            if (frame_tick)
              pause_cnt <= (pause_cnt == PAUSE_LAST) ? '0 : pause_cnt + 1'b1;
          end
          WIN: begin
            if (btn_shoot_p) begin
              level_rst <= 1'b1;
              step_cnt  <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
